movement_executor: RTL and testbench
====================================

// Module: movement_executor
// PURPOSE
// Downstream of the wall-following navigation FSM. Accepts one motion command
// (movement_sel + state_control), runs it on the two drive motors for a fixed
// number of PWM periods, then pulses done and waits for the next command.
// Converts the FSM's steady command levels into timed, speed-scaled motor drive.
// PARAMETERS
// PWM_PERIOD  100  clock cycles per PWM period; legal range >= 4
// FWD_TICKS   50   PWM periods per FORWARD command; legal range >= 1
// TURN_TICKS  25   PWM periods per TURN_LEFT/TURN_RIGHT command; legal range >= 1
// PORTS
// clk           in   1  system clock, rising edge
// rst           in   1  asynchronous, active-high reset
// cmd_valid     in   1  command present on movement_sel/state_control
// movement_sel  in   4  4'd0 STOP, 4'd1 TURN_RIGHT, 4'd2 TURN_LEFT, 4'd4 FORWARD; other codes = STOP
// state_control in   2  speed: 0 full duty, 1 half duty, 2 quarter duty, 3 = STOP
// abort         in   1  cancel current command
// cmd_ready     out  1  high only in IDLE
// busy          out  1  high only in RUN
// done          out  1  one-cycle pulse when a command completes
// motor_l_en    out  1  left motor PWM enable
// motor_l_dir   out  1  left motor direction (1 = forward)
// motor_r_en    out  1  right motor PWM enable
// motor_r_dir   out  1  right motor direction (1 = forward)
// BEHAVIOUR
// - Reset: state IDLE, all counters 0, latched command STOP; cmd_ready=1, busy=0, done=0, all motor_* = 0.
// - States: IDLE, RUN, DONE. Outputs decode from registered state, latched command and counters only;
//   no combinational input->output path.
// - IDLE: accept when cmd_valid=1 and abort=0: latch both command fields, clear counters.
//   Latched command STOP (code 0, unknown code, or state_control=3): next state DONE.
//   Otherwise: next state RUN.
// - abort=1 in IDLE blocks acceptance (abort wins over cmd_valid).
// - RUN: pwm_cnt counts 0..PWM_PERIOD-1 and wraps. At each wrap, tick_cnt increments.
//   Leave RUN on the wrap where tick_cnt == TICKS-1; TICKS is FWD_TICKS or TURN_TICKS.
//   RUN therefore lasts exactly TICKS*PWM_PERIOD cycles.
// - Duty: duty = PWM_PERIOD (speed 0), PWM_PERIOD>>1 (speed 1), PWM_PERIOD>>2 (speed 2).
//   en = (state==RUN) && (pwm_cnt < duty). en is high in the first RUN cycle.
// - Directions in RUN:
//   FORWARD l_dir=1, r_dir=1. TURN_RIGHT l_dir=1, r_dir=0. TURN_LEFT l_dir=0, r_dir=1.
//   Both dir = 0 outside RUN.
// - DONE: done=1 for exactly one cycle, motors off; next state IDLE.
//   Minimum accept-to-accept spacing is 2 cycles (STOP) or TICKS*PWM_PERIOD+2 cycles.
// - abort=1 in RUN: next state IDLE with no done pulse; motors off from the next cycle; counters cleared.
//   abort in DONE is ignored (done still pulses).
// - Inputs are ignored outside IDLE; command changes mid-RUN have no effect.
// - Counter widths: pwm_cnt $clog2(PWM_PERIOD); tick_cnt $clog2(max(FWD_TICKS,TURN_TICKS))+1.
//   No overflow is possible.
// - rst asserted mid-RUN returns immediately to reset values; motors off asynchronously.
// TESTING (bench params PWM_PERIOD=8, FWD_TICKS=3, TURN_TICKS=2)
// 1. Reset, then sel=4, speed=0, one-cycle cmd_valid -> busy for 24 cycles, both en=1 throughout,
//    both dir=1, done pulses on cycle 25, cmd_ready back on 26.
// 2. sel=1, speed=1 -> busy 16 cycles; l_en/r_en high at pwm_cnt 0-3, low at 4-7;
//    l_dir=1, r_dir=0; single done pulse.
// 3. sel=2, speed=2 -> en high only at pwm_cnt 0-1 of each period; l_dir=0, r_dir=1; 16 busy cycles.
// 4. sel=0, sel=4'd7, and speed=3 each -> no RUN, motors stay 0, done one cycle after accept.
// 5. FORWARD, abort at RUN cycle 10 -> IDLE next cycle, no done, motors 0; new command accepted after.
// 6. FORWARD, then assert rst at RUN cycle 5 -> all outputs 0 immediately; cmd_ready=1.
//    Also check cmd_valid and abort together in IDLE -> not accepted.

Source files
------------

// File: rtl/movement_executor.sv
// movement_executor: runs one latched motion command on the two drive motors
// for a fixed number of PWM periods, then pulses done and returns to IDLE.
// Motor enables are a PWM whose duty depends on the latched speed; directions
// depend on the latched movement. All outputs decode from registers only.
module movement_executor #(
  parameter int PWM_PERIOD = 100,
  parameter int FWD_TICKS  = 50,
  parameter int TURN_TICKS = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [3:0] movement_sel,
  input  logic [1:0] state_control,
  input  logic       abort,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       motor_l_en,
  output logic       motor_l_dir,
  output logic       motor_r_en,
  output logic       motor_r_dir
);

  localparam int PW   = $clog2(PWM_PERIOD);
  localparam int MAXT = (FWD_TICKS > TURN_TICKS) ? FWD_TICKS : TURN_TICKS;
  localparam int TW   = $clog2(MAXT) + 1;

  localparam logic [3:0] SEL_RIGHT = 4'd1;
  localparam logic [3:0] SEL_LEFT  = 4'd2;
  localparam logic [3:0] SEL_FWD   = 4'd4;

  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
  localparam logic [TW-1:0] FWD_LAST  = TW'(FWD_TICKS - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_TICKS - 1);

  // Duty thresholds are one bit wider than pwm_cnt so full duty fits.
  localparam logic [PW:0] DUTY_FULL    = (PW+1)'(PWM_PERIOD);
  localparam logic [PW:0] DUTY_HALF    = (PW+1)'(PWM_PERIOD >> 1);
  localparam logic [PW:0] DUTY_QUARTER = (PW+1)'(PWM_PERIOD >> 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   pwm_cnt;
  logic [TW-1:0]   tick_cnt;
  logic [3:0]      sel_q;
  logic [1:0]      spd_q;
  logic [TW-1:0]   tick_last;
  logic [PW:0]     duty;
  logic            pwm_on;

  // A command does nothing (goes straight to DONE) for speed 3 or any
  // movement code other than the three real motions.
  function automatic logic is_stop(input logic [3:0] sel, input logic [1:0] spd);
    return (spd == 2'd3) ||
           !((sel == SEL_RIGHT) || (sel == SEL_LEFT) || (sel == SEL_FWD));
  endfunction

  function automatic logic [PW:0] duty_of(input logic [1:0] spd);
    case (spd)
      2'd0:    return DUTY_FULL;
      2'd1:    return DUTY_HALF;
      2'd2:    return DUTY_QUARTER;
      default: return '0;
    endcase
  endfunction

  assign tick_last = (sel_q == SEL_FWD) ? FWD_LAST : TURN_LAST;
  assign duty      = duty_of(spd_q);

  // Command sequencer: accept in IDLE, count PWM periods in RUN, pulse DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pwm_cnt  <= '0;
      tick_cnt <= '0;
      sel_q    <= '0;
      spd_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && !abort) begin
            sel_q    <= movement_sel;
            spd_q    <= state_control;
            pwm_cnt  <= '0;
            tick_cnt <= '0;
            state    <= is_stop(movement_sel, state_control) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            pwm_cnt  <= '0;
            tick_cnt <= '0;
            state    <= S_IDLE;
          end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
            if (tick_cnt == tick_last) begin
              tick_cnt <= '0;
              state    <= S_DONE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // abort is deliberately ignored here so done always pulses
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from registered state, latched command and counters.
  always_comb begin
    pwm_on      = ({1'b0, pwm_cnt} < duty);
    cmd_ready   = (state == S_IDLE);
    busy        = (state == S_RUN);
    done        = (state == S_DONE);
    motor_l_en  = busy && pwm_on;
    motor_r_en  = busy && pwm_on;
    motor_l_dir = busy && ((sel_q == SEL_FWD) || (sel_q == SEL_RIGHT));
    motor_r_dir = busy && ((sel_q == SEL_FWD) || (sel_q == SEL_LEFT));
  end

endmodule

// File: tb/tb_movement_executor.sv
// Bench for movement_executor: a cycle-level reference model (elapsed run
// cycles with modulo arithmetic) checked every cycle, plus directed commands
// with hand-computed busy/enable/done counts.
module tb_movement_executor;

  localparam int P  = 8;
  localparam int FT = 3;
  localparam int TT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [3:0] movement_sel;
  logic [1:0] state_control;
  logic       abort;
  logic       cmd_ready, busy, done;
  logic       motor_l_en, motor_l_dir, motor_r_en, motor_r_dir;

  int checks = 0;
  int errors = 0;

  movement_executor #(.PWM_PERIOD(P), .FWD_TICKS(FT), .TURN_TICKS(TT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .movement_sel(movement_sel),
    .state_control(state_control), .abort(abort), .cmd_ready(cmd_ready),
    .busy(busy), .done(done), .motor_l_en(motor_l_en), .motor_l_dir(motor_l_dir),
    .motor_r_en(motor_r_en), .motor_r_dir(motor_r_dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 finished; k = cycles spent running.
  int         m_mode = 0;
  int         m_k = 0;
  logic [3:0] m_sel = '0;
  logic [1:0] m_spd = '0;

  function automatic bit m_is_motion(input logic [3:0] s, input logic [1:0] v);
    return (v != 2'd3) && (s == 4'd1 || s == 4'd2 || s == 4'd4);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_k = 0; m_sel = '0; m_spd = '0;
    end else begin
      case (m_mode)
        0: if (cmd_valid && !abort) begin
             m_sel = movement_sel; m_spd = state_control; m_k = 0;
             m_mode = m_is_motion(movement_sel, state_control) ? 1 : 2;
           end
        1: if (abort) begin
             m_mode = 0; m_k = 0;
           end else begin
             m_k++;
             if (m_k == ((m_sel == 4'd4) ? FT : TT) * P) m_mode = 2;
           end
        default: m_mode = 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int duty;
    bit en;
    duty = P >> m_spd;
    en   = (m_mode == 1) && ((m_k % P) < duty);
    chk("cmd_ready", int'(cmd_ready), int'(m_mode == 0));
    chk("busy", int'(busy), int'(m_mode == 1));
    chk("done", int'(done), int'(m_mode == 2));
    chk("l_en", int'(motor_l_en), int'(en));
    chk("r_en", int'(motor_r_en), int'(en));
    chk("l_dir", int'(motor_l_dir), int'((m_mode == 1) && (m_sel == 4'd4 || m_sel == 4'd1)));
    chk("r_dir", int'(motor_r_dir), int'((m_mode == 1) && (m_sel == 4'd4 || m_sel == 4'd2)));
  end

  // Issue a one-cycle command and measure it against hand-computed numbers.
  task automatic run_cmd(input logic [3:0] sel, input logic [1:0] spd,
                         input int exp_busy, input int exp_en,
                         input int exp_ldir, input int exp_rdir);
    int nbusy = 0, nen = 0, ndone = 0, done_at = -1, ready_at = -1;
    movement_sel = sel; state_control = spd; cmd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (i == 0) begin
        chk("first_l_dir", int'(motor_l_dir), exp_ldir);
        chk("first_r_dir", int'(motor_r_dir), exp_rdir);
      end
      if (busy) nbusy++;
      if (motor_l_en) nen++;
      if (done) begin ndone++; done_at = i; end
      if (cmd_ready) begin ready_at = i; break; end
    end
    chk("busy_cycles", nbusy, exp_busy);
    chk("en_cycles", nen, exp_en);
    chk("done_pulses", ndone, 1);
    chk("done_at", done_at, exp_busy);
    chk("ready_at", ready_at, exp_busy + 1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; movement_sel = '0; state_control = '0; abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_motors", int'({motor_l_en, motor_l_dir, motor_r_en, motor_r_dir}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Forward full speed, right turn half speed, left turn quarter speed.
    run_cmd(4'd4, 2'd0, 24, 24, 1, 1);
    run_cmd(4'd1, 2'd1, 16, 8, 1, 0);
    run_cmd(4'd2, 2'd2, 16, 4, 0, 1);
    // Commands that never run the motors.
    run_cmd(4'd0, 2'd0, 0, 0, 0, 0);
    run_cmd(4'd7, 2'd0, 0, 0, 0, 0);
    run_cmd(4'd4, 2'd3, 0, 0, 0, 0);

    // Abort during RUN: back to IDLE next cycle without done.
    movement_sel = 4'd4; state_control = 2'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_abort_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_motors", int'({motor_l_en, motor_l_dir, motor_r_en, motor_r_dir}), 0);
    @(negedge clk);
    chk("abort_no_late_done", int'(done), 0);
    run_cmd(4'd2, 2'd0, 16, 16, 0, 1);

    // Asynchronous reset in the middle of RUN.
    movement_sel = 4'd4; state_control = 2'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_en", int'(motor_l_en), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_motors", int'({motor_l_en, motor_l_dir, motor_r_en, motor_r_dir}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // cmd_valid together with abort in IDLE is not accepted.
    movement_sel = 4'd4; state_control = 2'd0; cmd_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    chk("blocked_ready", int'(cmd_ready), 1);
    chk("blocked_busy", int'(busy), 0);
    chk("blocked_done", int'(done), 0);
    @(negedge clk);
    run_cmd(4'd1, 2'd0, 16, 16, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
